fifo32_8: RTL and testbench

//  Word-to-byte down-converting FIFO for the RS-232 transmit path. A host writes
//  32-bit words; the UART transmitter pops them one byte at a time, little-endian.
//  It is the transmit-side counterpart of the 8-to-32 receive FIFO.
//  It buffers DEPTH_W words and reports empty, full, level and sticky error flags.

---
 rtl/fifo32_8_if.sv | 41 ++++
 rtl/fifo32_8.sv | 94 +++++++++
 tb/tb_fifo32_8.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo32_8_if.sv
// rtl/fifo32_8_if.sv - host/UART-side signal bundle for the 32-to-8 transmit FIFO
//
// Purpose: groups the push, pop, status and error-clear signals of fifo32_8.
//
// Ports (signals):
//   wdata_i[31:0]  word to push
//   wr_i           push strobe
//   rd_i           pop strobe
//   clr_err_i      clear of the sticky error flags
//   rdata_o[7:0]   head byte, zero-latency
//   empty_o        no bytes available
//   full_o         no free word slot
//   level_o        bytes available, 0..4*DEPTH_W
//   ovf_o / udf_o  sticky overflow / underflow flags
//
// Modports: master = host + UART transmitter side, slave = the FIFO.

interface fifo32_8_if #(
   parameter int AW = 2
);
   logic [31:0]   wdata_i;
   logic          wr_i;
   logic          rd_i;
   logic          clr_err_i;
   logic [7:0]    rdata_o;
   logic          empty_o;
   logic          full_o;
   logic [AW+2:0] level_o;
   logic          ovf_o;
   logic          udf_o;

   modport master (
      output wdata_i, wr_i, rd_i, clr_err_i,
      input  rdata_o, empty_o, full_o, level_o, ovf_o, udf_o
   );

   modport slave (
      input  wdata_i, wr_i, rd_i, clr_err_i,
      output rdata_o, empty_o, full_o, level_o, ovf_o, udf_o
   );
endinterface

// File: rtl/fifo32_8.sv
// rtl/fifo32_8.sv - 32-bit word in, 8-bit byte out transmit FIFO
//
// Purpose: the host pushes 32-bit words, the UART transmitter pops them a byte
// at a time, least significant byte first. Buffers DEPTH_W words and reports
// empty, full, byte level and sticky overflow/underflow flags.
//
// Ports:
//   sclk   system clock, rising edge
//   rstn   asynchronous active-low reset; clears pointers, memory and flags
//   bus    fifo32_8_if.slave (see the interface file for signal list)

module fifo32_8 #(
   parameter int DEPTH_W = 4,
   parameter int AW      = 2
) (
   input  logic       sclk,
   input  logic       rstn,
   fifo32_8_if.slave  bus
);

   // wptr counts words, rptr counts bytes; both carry one extra lap bit.
   logic [AW:0]   wptr;
   logic [AW+2:0] rptr;
   logic [31:0]   mem [DEPTH_W];

   logic          empty;
   logic          full;
   logic          push_ok;
   logic          pop_ok;
   logic [31:0]   head_word;
   logic [7:0]    head_byte;
   logic          ovf;
   logic          udf;

   // The word index of rptr only advances after the 4th byte of a word is
   // popped, so a partially-read slot still counts as occupied for full.
   assign empty = (rptr[AW+2:2] == wptr);
   assign full  = (rptr[AW+2] != wptr[AW]) && (rptr[AW+1:2] == wptr[AW-1:0]);

   // Both strobes are qualified on the pre-edge state.
   assign push_ok = bus.wr_i && !full;
   assign pop_ok  = bus.rd_i && !empty;

   assign head_word = mem[rptr[AW+1:2]];

   always_comb begin
      head_byte = 8'h00;
      case (rptr[1:0])
         2'd0:    head_byte = head_word[7:0];
         2'd1:    head_byte = head_word[15:8];
         2'd2:    head_byte = head_word[23:16];
         default: head_byte = head_word[31:24];
      endcase
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         wptr <= '0;
         rptr <= '0;
         ovf  <= 1'b0;
         udf  <= 1'b0;
         for (int i = 0; i < DEPTH_W; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wptr[AW-1:0]] <= bus.wdata_i;
            wptr              <= wptr + 1'b1;
         end
         if (pop_ok) begin
            rptr <= rptr + 1'b1;
         end
         // A new error in the clearing cycle wins over the clear.
         if (bus.wr_i && full) begin
            ovf <= 1'b1;
         end else if (bus.clr_err_i) begin
            ovf <= 1'b0;
         end
         if (bus.rd_i && empty) begin
            udf <= 1'b1;
         end else if (bus.clr_err_i) begin
            udf <= 1'b0;
         end
      end
   end

   assign bus.rdata_o = empty ? 8'h00 : head_byte;
   assign bus.empty_o = empty;
   assign bus.full_o  = full;
   assign bus.level_o = {wptr, 2'b00} - rptr;
   assign bus.ovf_o   = ovf;
   assign bus.udf_o   = udf;

endmodule

// File: tb/tb_fifo32_8.sv
// tb/tb_fifo32_8.sv - scoreboard bench for fifo32_8 against a byte-queue model

module tb_fifo32_8;

   localparam int DEPTH_W = 4;
   localparam int AW      = 2;

   typedef struct {
      logic [7:0]    rdata;
      logic          empty;
      logic          full;
      logic [AW+2:0] level;
      logic          ovf;
      logic          udf;
   } stat_t;

   logic sclk = 1'b0;
   logic rstn = 1'b0;

   fifo32_8_if #(.AW(AW)) bus ();

   fifo32_8 #(.DEPTH_W(DEPTH_W), .AW(AW)) dut (
      .sclk (sclk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 sclk = ~sclk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: bytes in FIFO order plus the two sticky flags.
   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;
   logic       m_udf = 1'b0;

   logic [7:0] exp_q[$];
   stat_t      stat_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_words();
      return (mq.size() + 3) / 4;
   endfunction

   function automatic bit m_full();
      return m_words() == DEPTH_W;
   endfunction

   function automatic void m_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endfunction

   // One clock of stimulus. Expected pre-edge status is queued for the monitor,
   // an accepted pop queues its expected byte, then the model advances.
   task automatic step(input bit wr, input logic [31:0] d, input bit rd, input bit clr);
      stat_t st;
      bit    full_pre;
      bit    empty_pre;
      @(negedge sclk);
      bus.wr_i      = wr;
      bus.wdata_i   = d;
      bus.rd_i      = rd;
      bus.clr_err_i = clr;
      full_pre  = m_full();
      empty_pre = (mq.size() == 0);
      st.level = (AW+3)'(mq.size());
      st.empty = empty_pre;
      st.full  = full_pre;
      st.ovf   = m_ovf;
      st.udf   = m_udf;
      st.rdata = empty_pre ? 8'h00 : mq[0];
      stat_q.push_back(st);
      if (rd && !empty_pre) begin
         exp_q.push_back(mq[0]);
         void'(mq.pop_front());
      end
      if (wr && !full_pre) begin
         for (int b = 0; b < 4; b++) mq.push_back(d[8*b +: 8]);
      end
      if (wr && full_pre)  m_ovf = 1'b1;
      else if (clr)        m_ovf = 1'b0;
      if (rd && empty_pre) m_udf = 1'b1;
      else if (clr)        m_udf = 1'b0;
   endtask

   // Monitor: checks status every stimulated cycle and each byte the DUT hands out.
   initial begin
      stat_t st;
      forever begin
         @(negedge sclk);
         #2;
         if (stat_q.size() != 0) begin
            st = stat_q.pop_front();
            chk("level", 32'(bus.level_o), 32'(st.level));
            chk("empty", 32'(bus.empty_o), 32'(st.empty));
            chk("full",  32'(bus.full_o),  32'(st.full));
            chk("ovf",   32'(bus.ovf_o),   32'(st.ovf));
            chk("udf",   32'(bus.udf_o),   32'(st.udf));
            chk("rdata", 32'(bus.rdata_o), 32'(st.rdata));
            if (bus.rd_i && !bus.empty_o) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_pop", 32'(bus.rdata_o), 32'hFFFF_FFFF);
               end else begin
                  chk("pop_byte", 32'(bus.rdata_o), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_empty"}, 32'(bus.empty_o), 32'd1);
      chk({tag, "_full"},  32'(bus.full_o),  32'd0);
      chk({tag, "_level"}, 32'(bus.level_o), 32'd0);
      chk({tag, "_rdata"}, 32'(bus.rdata_o), 32'd0);
      chk({tag, "_ovf"},   32'(bus.ovf_o),   32'd0);
      chk({tag, "_udf"},   32'(bus.udf_o),   32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.wr_i      = 1'b0;
      bus.rd_i      = 1'b0;
      bus.clr_err_i = 1'b0;
      bus.wdata_i   = '0;
      #3;
      check_reset_outputs("reset");
      @(negedge sclk);
      rstn = 1'b1;

      // Single word, four pops, little-endian order.
      step(1, 32'h4433_2211, 0, 0);
      repeat (4) step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // Fill, overflow, drain.
      for (int i = 0; i < 4; i++) step(1, 32'h1000_0000 * (i + 1) + 32'h0001_0203 * i, 0, 0);
      step(1, 32'hDEAD_BEEF, 0, 0);
      repeat (16) step(0, 0, 1, 0);
      step(0, 0, 0, 1);

      // Simultaneous push and pop at full.
      for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0);
      step(1, 32'hCAFE_F00D, 1, 0);
      repeat (3) step(0, 0, 1, 0);
      step(1, 32'h8765_4321, 0, 0);
      step(0, 0, 0, 1);
      repeat (16) step(0, 0, 1, 0);
      step(0, 0, 0, 1);

      // Stream 12 words with continuous pops across pointer wrap.
      k = 0;
      while (k < 12 || mq.size() != 0) begin
         if (k < 12 && !m_full()) begin
            step(1, 32'h0403_0201 + k * 32'h0404_0404, 1, 0);
            k++;
         end else begin
            step(0, 0, 1, 0);
         end
      end
      step(0, 0, 0, 1);

      // Underflow, clear, clear racing a new underflow.
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      step(0, 0, 1, 0);
      step(0, 0, 1, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);

      // Asynchronous reset mid-operation.
      step(1, 32'hA1A2_A3A4, 0, 0);
      step(1, 32'hB1B2_B3B4, 0, 0);
      repeat (3) step(0, 0, 1, 0);
      step(1, 32'hFFFF_FFFF, 1, 0);
      step(1, 32'hEEEE_EEEE, 0, 0);
      @(posedge sclk);
      bus.wr_i = 1'b0;
      bus.rd_i = 1'b0;
      bus.clr_err_i = 1'b0;
      #2 rstn = 1'b0;
      #1 check_reset_outputs("async_reset");
      m_reset();
      #1 rstn = 1'b1;
      step(1, 32'h7766_5544, 0, 0);
      repeat (4) step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 50, $urandom, $urandom_range(0, 99) < 60,
              $urandom_range(0, 99) < 5);
      end
      step(0, 0, 0, 0);

      @(negedge sclk);
      #4;
      chk("leftover_expected_bytes", 32'(exp_q.size()), 32'd0);
      chk("leftover_status", 32'(stat_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
